cache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate cache controller that sits between a CPU-side requester and `main_memory`. It is the initiator on the `main_memory` req/ready/done handshake. Read hits are served locally in two cycles. Read misses and all writes are forwarded to memory and complete when memory pulses done.

---
 rtl/cache_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller.
// Read hits complete locally two cycles after the request. Read misses and all
// writes go to main memory over a req/ready/done handshake.
//
// Optional feature macro: CACHE_STATS_EN adds 16-bit hit_cnt / miss_cnt outputs.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cpu_req/we/addr/wdata (in)      CPU request, sampled when cpu_ready=1
//   cpu_ready/done/rdata (out)      idle flag, completion pulse, read data (held)
//   mem_req/we/addr/wdata (out)     memory request, held until accepted
//   mem_ready/done/rdata (in)       memory idle, completion pulse, read data
//   hit_cnt/miss_cnt (out)          read hit / read miss counters (CACHE_STATS_EN only)
module cache_ctrl #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned INDEX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
`endif
);

   localparam int unsigned TAG_W = ADDR_W - INDEX_W;
   localparam int unsigned LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOOKUP,
      S_MEM_REQ,
      S_MEM_WAIT
   } state_t;

   state_t state, state_nxt;

   // line storage
   logic [LINES-1:0]  line_valid;
   logic [TAG_W-1:0]  line_tag  [LINES];
   logic [DATA_W-1:0] line_data [LINES];

   // latched request
   logic              req_we,    req_we_nxt;
   logic [ADDR_W-1:0] req_addr,  req_addr_nxt;
   logic [DATA_W-1:0] req_wdata, req_wdata_nxt;

   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic               hit_c;

   // next values of registered outputs
   logic              cpu_ready_nxt;
   logic              cpu_done_nxt;
   logic [DATA_W-1:0] cpu_rdata_nxt;
   logic              mem_req_nxt;
   logic              mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt;

   // line write port: read fill or write-hit update
   logic              line_wr_en;
   logic [DATA_W-1:0] line_wr_data;

`ifdef CACHE_STATS_EN
   logic hit_inc;
   logic miss_inc;
`endif

   assign req_idx = req_addr[INDEX_W-1:0];
   assign req_tag = req_addr[ADDR_W-1:INDEX_W];
   // Lines only change in MEM_WAIT on this controller's own request, so the
   // hit computed from the latched address is still valid in MEM_WAIT.
   assign hit_c   = line_valid[req_idx] && (line_tag[req_idx] == req_tag);

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      req_we_nxt    = req_we;
      req_addr_nxt  = req_addr;
      req_wdata_nxt = req_wdata;
      cpu_done_nxt  = 1'b0;
      cpu_rdata_nxt = cpu_rdata;
      mem_req_nxt   = mem_req;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      line_wr_en    = 1'b0;
      line_wr_data  = req_wdata;
`ifdef CACHE_STATS_EN
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;
`endif

      case (state)
         S_IDLE: begin
            if (cpu_req && cpu_ready) begin
               req_we_nxt    = cpu_we;
               req_addr_nxt  = cpu_addr;
               req_wdata_nxt = cpu_wdata;
               state_nxt     = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            if (!req_we && hit_c) begin
               cpu_rdata_nxt = line_data[req_idx];
               cpu_done_nxt  = 1'b1;
               state_nxt     = S_IDLE;
`ifdef CACHE_STATS_EN
               hit_inc       = 1'b1;
`endif
            end else begin
               mem_req_nxt   = 1'b1;
               mem_we_nxt    = req_we;
               mem_addr_nxt  = req_addr;
               mem_wdata_nxt = req_wdata;
               state_nxt     = S_MEM_REQ;
`ifdef CACHE_STATS_EN
               miss_inc      = !req_we;
`endif
            end
         end

         S_MEM_REQ: begin
            if (mem_ready) begin
               mem_req_nxt = 1'b0;
               state_nxt   = S_MEM_WAIT;
            end
         end

         S_MEM_WAIT: begin
            if (mem_done) begin
               if (!req_we) begin
                  line_wr_en    = 1'b1;
                  line_wr_data  = mem_rdata;
                  cpu_rdata_nxt = mem_rdata;
               end else if (hit_c) begin
                  line_wr_en    = 1'b1;
               end
               cpu_done_nxt = 1'b1;
               state_nxt    = S_IDLE;
            end
         end

         default: state_nxt = S_IDLE;
      endcase

      cpu_ready_nxt = (state_nxt == S_IDLE);
   end

   // State, request latch and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         line_valid <= '0;
         req_we     <= 1'b0;
         req_addr   <= '0;
         req_wdata  <= '0;
         cpu_ready  <= 1'b1;
         cpu_done   <= 1'b0;
         cpu_rdata  <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state     <= state_nxt;
         req_we    <= req_we_nxt;
         req_addr  <= req_addr_nxt;
         req_wdata <= req_wdata_nxt;
         cpu_ready <= cpu_ready_nxt;
         cpu_done  <= cpu_done_nxt;
         cpu_rdata <= cpu_rdata_nxt;
         mem_req   <= mem_req_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         if (line_wr_en) begin
            line_valid[req_idx] <= 1'b1;
         end
      end
   end

   // Tag/data arrays need no reset; validity is tracked by line_valid
   always_ff @(posedge clk) begin
      if (rst_n && line_wr_en) begin
         line_tag[req_idx]  <= req_tag;
         line_data[req_idx] <= line_wr_data;
      end
   end

`ifdef CACHE_STATS_EN
   // Read hit/miss counters, wrap naturally at 16 bits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit_inc) begin
            hit_cnt <= hit_cnt + 16'd1;
         end
         if (miss_inc) begin
            miss_cnt <= miss_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Testbench for cache_ctrl: memory model with LATENCY=8 preloaded mem[i]=i,
// directed vector table, hand-written stall/reset sequences and random traffic
// checked against a behavioural cache/memory model.
module tb_cache_ctrl;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned INDEX_W = 4;
   localparam int          LATENCY = 8;
   localparam int          MISS_LAT = LATENCY + 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cpu_req = 1'b0;
   logic              cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic              cpu_ready;
   logic              cpu_done;
   logic [DATA_W-1:0] cpu_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic              mem_done = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
   logic [15:0]       hit_cnt;
   logic [15:0]       miss_cnt;
`endif

   always #5 clk = ~clk;

   cache_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .INDEX_W(INDEX_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready),
      .cpu_done (cpu_done),
      .cpu_rdata(cpu_rdata),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ready(mem_ready),
      .mem_done (mem_done),
      .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   // ---------------- main memory model ----------------
   logic [DATA_W-1:0] mem [0:65535];
   logic              busy = 1'b0;
   logic              mem_hold = 1'b0;
   int                cnt = 0;
   int                acc_count = 0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic              m_we = 1'b0;
   logic [DATA_W-1:0] m_wdata = '0;

   assign mem_ready = !busy && !mem_hold;

   // accept at edge A, pulse done after edge A+LATENCY+1
   always @(posedge clk) begin
      mem_done <= 1'b0;
      if (busy) begin
         if (cnt == 0) begin
            mem_done  <= 1'b1;
            busy      <= 1'b0;
            mem_rdata <= mem[m_addr];
            if (m_we) mem[m_addr] <= m_wdata;
         end else begin
            cnt <= cnt - 1;
         end
      end else if (mem_req && mem_ready) begin
         busy      <= 1'b1;
         cnt       <= LATENCY;
         m_addr    <= mem_addr;
         m_we      <= mem_we;
         m_wdata   <= mem_wdata;
         acc_count <= acc_count + 1;
      end
   end

   // ---------------- checking ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- behavioural reference model ----------------
   bit                ref_valid [16];
   logic [11:0]       ref_tag   [16];
   logic [DATA_W-1:0] ref_mem   [int];
   logic [DATA_W-1:0] ref_prev_rdata = '0;
   int                ref_hits = 0;
   int                ref_misses = 0;

   function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return 32'(a);
   endfunction

   task automatic ref_reset();
      for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
      ref_prev_rdata = '0;
      ref_hits = 0;
      ref_misses = 0;
   endtask

   // predicts one transaction and updates the model state
   task automatic ref_txn(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                          output logic [DATA_W-1:0] exp_rd, output int exp_lat, output int exp_req);
      int  idx;
      bit  hit;
      idx = int'(a % 16);
      hit = ref_valid[idx] && (ref_tag[idx] == 12'(a / 16));
      if (we) begin
         exp_lat = MISS_LAT;
         exp_req = 1;
         exp_rd  = ref_prev_rdata;
         ref_mem[int'(a)] = wd;
      end else begin
         exp_rd  = ref_read(a);
         if (hit) begin
            exp_lat = 1;
            exp_req = 0;
            ref_hits++;
         end else begin
            exp_lat = MISS_LAT;
            exp_req = 1;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = 12'(a / 16);
            ref_misses++;
         end
         ref_prev_rdata = exp_rd;
      end
   endtask

   // drives one request; returns rdata at cpu_done, edges E0->done, memory accepts
   task automatic run_txn(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                          input int hold, output logic [DATA_W-1:0] rd, output int lat, output int nreq);
      int a0;
      a0        = acc_count;
      mem_hold  = (hold > 0);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = wd;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      lat = -1;
      rd  = cpu_rdata;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (hold > 0 && k >= 2 && k <= hold) begin
            check($sformatf("stall_req_k%0d", k), 64'(mem_req), 64'd1);
            check($sformatf("stall_addr_k%0d", k), 64'(mem_addr), 64'(a));
         end
         if (k == hold) mem_hold = 1'b0;
         if (cpu_done) begin
            lat = k;
            rd  = cpu_rdata;
            break;
         end
      end
      mem_hold = 1'b0;
      nreq = acc_count - a0;
   endtask

   task automatic compare_txn(input string tag, input bit we, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd,
                              input int exp_lat, input int exp_req, input logic [DATA_W-1:0] rd,
                              input int lat, input int nreq);
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_mem_reqs"}, 64'(nreq), 64'(exp_req));
      check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
      if (nreq == 1 && exp_req == 1) begin
         check({tag, "_mem_addr"}, 64'(m_addr), 64'(a));
         check({tag, "_mem_we"}, 64'(m_we), 64'(we));
         if (we) check({tag, "_mem_wdata"}, 64'(m_wdata), 64'(wd));
      end
   endtask

   typedef struct {
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] exp_rd;
      int                exp_lat;
      int                exp_req;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [DATA_W-1:0] rd, m_rd;
      int                lat, nreq, m_lat, m_req;
      bit                saw_done;

      for (int i = 0; i < 65536; i++) mem[i] <= 32'(i);

      vecs[0] = '{1'b0, 16'h0012, 32'h0,        32'h0000_0012, MISS_LAT, 1};
      vecs[1] = '{1'b0, 16'h0012, 32'h0,        32'h0000_0012, 1,        0};
      vecs[2] = '{1'b1, 16'h0012, 32'hDEADBEEF, 32'h0000_0012, MISS_LAT, 1};
      vecs[3] = '{1'b0, 16'h0012, 32'h0,        32'hDEADBEEF, 1,        0};
      vecs[4] = '{1'b0, 16'h0112, 32'h0,        32'h0000_0112, MISS_LAT, 1};
      vecs[5] = '{1'b0, 16'h0012, 32'h0,        32'hDEADBEEF, MISS_LAT, 1};
      vecs[6] = '{1'b1, 16'h0040, 32'h0000_0055, 32'hDEADBEEF, MISS_LAT, 1};
      vecs[7] = '{1'b0, 16'h0040, 32'h0,        32'h0000_0055, MISS_LAT, 1};

      // reset state
      ref_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cpu_ready", 64'(cpu_ready), 64'd1);
      check("rst_cpu_done",  64'(cpu_done),  64'd0);
      check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
      check("rst_mem_req",   64'(mem_req),   64'd0);
      check("rst_mem_we",    64'(mem_we),    64'd0);
      check("rst_mem_addr",  64'(mem_addr),  64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
`ifdef CACHE_STATS_EN
      check("rst_hit_cnt",  64'(hit_cnt),  64'd0);
      check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed vector table
      for (int i = 0; i < 8; i++) begin
         ref_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, m_rd, m_lat, m_req);
         run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, rd, lat, nreq);
         compare_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                     vecs[i].exp_rd, vecs[i].exp_lat, vecs[i].exp_req, rd, lat, nreq);
`ifdef CACHE_STATS_EN
         if (i == 1) begin
            check("vec1_hit_cnt",  64'(hit_cnt),  64'd1);
            check("vec1_miss_cnt", 64'(miss_cnt), 64'd1);
         end
`endif
      end
      check("mem_0012_written", 64'(mem[16'h0012]), 64'hDEADBEEF);
      check("mem_0040_written", 64'(mem[16'h0040]), 64'h0000_0055);

      // memory not ready: request must be held with stable address
      ref_txn(1'b0, 16'h0023, 32'h0, m_rd, m_lat, m_req);
      run_txn(1'b0, 16'h0023, 32'h0, 5, rd, lat, nreq);
      compare_txn("stall", 1'b0, 16'h0023, 32'h0, 32'h0000_0023, 16, 1, rd, lat, nreq);

      // reset during MEM_WAIT of a read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005; cpu_wdata = '0;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_in_wait_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_cpu_ready", 64'(cpu_ready), 64'd1);
      check("midrst_cpu_done",  64'(cpu_done),  64'd0);
      check("midrst_mem_req",   64'(mem_req),   64'd0);
      check("midrst_cpu_rdata", 64'(cpu_rdata), 64'd0);
      rst_n = 1'b1;
      ref_reset();
      saw_done = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (cpu_done) saw_done = 1'b1;
      end
      check("midrst_stale_done_ignored", 64'(saw_done), 64'd0);
      for (int k = 0; k < 50 && !mem_ready; k++) begin
         @(posedge clk); #1;
      end
      check("midrst_mem_ready", 64'(mem_ready), 64'd1);
      ref_txn(1'b0, 16'h0003, 32'h0, m_rd, m_lat, m_req);
      run_txn(1'b0, 16'h0003, 32'h0, 0, rd, lat, nreq);
      compare_txn("post_rst_0003", 1'b0, 16'h0003, 32'h0, 32'h0000_0003, MISS_LAT, 1, rd, lat, nreq);
      // valid bits were cleared: a previously cached line misses again
      ref_txn(1'b0, 16'h0012, 32'h0, m_rd, m_lat, m_req);
      run_txn(1'b0, 16'h0012, 32'h0, 0, rd, lat, nreq);
      compare_txn("post_rst_0012", 1'b0, 16'h0012, 32'h0, 32'hDEADBEEF, MISS_LAT, 1, rd, lat, nreq);

      // random traffic against the reference model
      for (int i = 0; i < 150; i++) begin
         logic [11:0]       tg;
         logic [3:0]        ix;
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] wd;
         bit                we;
         int                hold;
         case ($urandom_range(0, 3))
            0:       tg = 12'h000;
            1:       tg = 12'h001;
            2:       tg = 12'h002;
            default: tg = 12'hFFF;
         endcase
         ix   = 4'($urandom_range(0, 15));
         a    = {tg, ix};
         we   = ($urandom_range(0, 9) < 3);
         wd   = $urandom;
         hold = ($urandom_range(0, 7) == 0) ? 3 : 0;
         ref_txn(we, a, wd, m_rd, m_lat, m_req);
         if (hold > 0 && m_req == 1) m_lat = 11 + hold;
         run_txn(we, a, wd, (m_req == 1) ? hold : 0, rd, lat, nreq);
         compare_txn($sformatf("rnd%0d", i), we, a, wd, m_rd, m_lat, m_req, rd, lat, nreq);
      end
`ifdef CACHE_STATS_EN
      check("final_hit_cnt",  64'(hit_cnt),  64'(ref_hits));
      check("final_miss_cnt", 64'(miss_cnt), 64'(ref_misses));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
